// File: rtl/apb4_pkg.sv
// Shared types and helpers for the APB4 register file: FSM state encoding,
// byte-lane geometry and the address legality check.
package apb4_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

   localparam int WAIT_CNT_W = 4;

   function automatic int strb_width(input int dw);
      return dw / 8;
   endfunction

   function automatic int addr_lsb(input int dw);
      return (dw == 32) ? 2 : ((dw == 16) ? 1 : 0);
   endfunction

   // True when the byte address is word aligned and selects an implemented register.
   function automatic logic addr_ok(input logic [31:0] addr, input int lsb, input int nregs);
      logic [31:0] mask;
      mask = (32'd1 << lsb) - 32'd1;
      return ((addr & mask) == 32'd0) && ((addr >> lsb) < 32'(nregs));
   endfunction

endpackage

// File: rtl/apb4_wait_ctrl.sv
// APB4 protocol FSM with wait-state counter; produces PREADY and flags
// an ACCESS phase that was entered without a SETUP phase.
module apb4_wait_ctrl
   import apb4_pkg::*;
#(
   parameter int WAIT_STATES = 0
)(
   input  logic pclk,
   input  logic preset,
   input  logic psel,
   input  logic penable,
   output logic pready,
   output logic proto_err
);

   localparam logic [WAIT_CNT_W-1:0] WS_CNT = WAIT_CNT_W'(WAIT_STATES);

   apb_state_e            state_r;
   logic [WAIT_CNT_W-1:0] cnt_r;
   logic                  perr_r;

   // Protocol state, wait counter and violation flag; the flag is held through ACCESS.
   always_ff @(posedge pclk) begin
      if (preset) begin
         state_r <= ST_IDLE;
         cnt_r   <= {WAIT_CNT_W{1'b0}};
         perr_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               cnt_r <= {WAIT_CNT_W{1'b0}};
               if (psel && !penable) begin
                  state_r <= ST_SETUP;
                  perr_r  <= 1'b0;
               end else if (psel && penable) begin
                  state_r <= ST_ACCESS;
                  perr_r  <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
                  perr_r  <= 1'b0;
               end
            end
            ST_SETUP: begin
               cnt_r  <= {WAIT_CNT_W{1'b0}};
               perr_r <= 1'b0;
               if (psel && penable) begin
                  state_r <= ST_ACCESS;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_ACCESS: begin
               if (!psel || (cnt_r == WS_CNT)) begin
                  state_r <= ST_IDLE;
                  cnt_r   <= {WAIT_CNT_W{1'b0}};
                  perr_r  <= 1'b0;
               end else begin
                  state_r <= ST_ACCESS;
                  cnt_r   <= cnt_r + {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
                  perr_r  <= perr_r;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= {WAIT_CNT_W{1'b0}};
               perr_r  <= 1'b0;
            end
         endcase
      end
   end

   assign pready    = (state_r == ST_ACCESS) && (cnt_r == WS_CNT);
   assign proto_err = perr_r;

endmodule

// File: rtl/apb4_regfile.sv
// Parametrised APB4 completer register bank with byte strobes, read-only
// status mapping, programmable wait states and PSLVERR reporting.
module apb4_regfile
   import apb4_pkg::*;
#(
   parameter int                  ADDR_WIDTH  = 8,
   parameter int                  DATA_WIDTH  = 32,
   parameter int                  NUM_REGS    = 16,
   parameter int                  WAIT_STATES = 0,
   parameter logic [NUM_REGS-1:0] RO_MASK     = '0
)(
   input  logic                         PCLK,
   input  logic                         PRESET,
   input  logic                         PSEL,
   input  logic                         PENABLE,
   input  logic                         PWRITE,
   input  logic [ADDR_WIDTH-1:0]        PADDR,
   input  logic [DATA_WIDTH-1:0]        PWDATA,
   input  logic [DATA_WIDTH/8-1:0]      PSTRB,
   output logic [DATA_WIDTH-1:0]        PRDATA,
   output logic                         PREADY,
   output logic                         PSLVERR,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

   localparam int STRB_WIDTH = strb_width(DATA_WIDTH);
   localparam int ADDR_LSB   = addr_lsb(DATA_WIDTH);

   logic                  pready_s;
   logic                  proto_err_s;
   logic [ADDR_WIDTH-1:0] idx_s;
   logic                  ro_hit_s;
   logic [DATA_WIDTH-1:0] rd_val_s;
   logic                  err_s;
   logic                  commit_s;
   logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];

   apb4_wait_ctrl #(
      .WAIT_STATES (WAIT_STATES)
   ) u_wait_ctrl (
      .pclk      (PCLK),
      .preset    (PRESET),
      .psel      (PSEL),
      .penable   (PENABLE),
      .pready    (pready_s),
      .proto_err (proto_err_s)
   );

   assign idx_s = PADDR >> ADDR_LSB;

   // Read mux and RO lookup; an AND-OR select keeps out-of-range indices at zero.
   always_comb begin
      ro_hit_s = 1'b0;
      rd_val_s = {DATA_WIDTH{1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
         ro_hit_s = ro_hit_s | ((idx_s == ADDR_WIDTH'(i)) & RO_MASK[i]);
         rd_val_s = rd_val_s | ({DATA_WIDTH{idx_s == ADDR_WIDTH'(i)}} &
                    (RO_MASK[i] ? hw_status[i*DATA_WIDTH +: DATA_WIDTH] : regs_r[i]));
      end
   end

   assign err_s    = !addr_ok(32'(PADDR), ADDR_LSB, NUM_REGS) | (PWRITE & ro_hit_s) | proto_err_s;
   assign commit_s = pready_s & PSEL & PENABLE & PWRITE & !err_s;

   // Register array with per-byte strobe merge on a committing write.
   always_ff @(posedge PCLK) begin
      for (int i = 0; i < NUM_REGS; i++) begin
         for (int b = 0; b < STRB_WIDTH; b++) begin
            if (PRESET) begin
               regs_r[i][b*8 +: 8] <= 8'd0;
            end else if (commit_s && (idx_s == ADDR_WIDTH'(i)) && PSTRB[b]) begin
               regs_r[i][b*8 +: 8] <= PWDATA[b*8 +: 8];
            end else begin
               regs_r[i][b*8 +: 8] <= regs_r[i][b*8 +: 8];
            end
         end
      end
   end

   genvar g;
   generate
      for (g = 0; g < NUM_REGS; g++) begin : g_regq
         assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[g] ? {DATA_WIDTH{1'b0}} : regs_r[g];
      end
   endgenerate

   assign PREADY  = pready_s;
   assign PSLVERR = pready_s & err_s;
   assign PRDATA  = (pready_s & !PWRITE & !err_s) ? rd_val_s : {DATA_WIDTH{1'b0}};

endmodule
